// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_pkg
// Purpose  : Shared AHB-Lite encodings and defaults for the data-side arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ahb_pkg;

  localparam int AHB_AW = 32;
  localparam int AHB_DW = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic {
    GRANT_M0 = 1'b0,
    GRANT_M1 = 1'b1
  } master_e;

  // SEQ is handled exactly like NONSEQ, so bursts are re-arbitrated per beat.
  function automatic logic htrans_is_xfer(input logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_pend_slot.sv
`default_nettype none
// ============================================================================
// Module   : ahb_pend_slot
// Purpose  : One-entry address-phase holding slot; forwards the held transfer
//            while valid, otherwise the live master inputs.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_pend_slot
  import ahb_pkg::*;
#(
  parameter int AW = AHB_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_capture,
  input  logic          i_clear,
  input  logic [AW-1:0] i_haddr,
  input  logic          i_hwrite,
  input  logic [2:0]    i_hsize,
  input  logic [2:0]    i_hburst,
  input  logic [3:0]    i_hprot,
  output logic          o_pend_v,
  output logic [AW-1:0] o_haddr,
  output logic          o_hwrite,
  output logic [2:0]    o_hsize,
  output logic [2:0]    o_hburst,
  output logic [3:0]    o_hprot
);

  logic          r_pend_v;
  logic [AW-1:0] r_haddr;
  logic          r_hwrite;
  logic [2:0]    r_hsize;
  logic [2:0]    r_hburst;
  logic [3:0]    r_hprot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_v <= 1'b0;
      r_haddr  <= '0;
      r_hwrite <= 1'b0;
      r_hsize  <= '0;
      r_hburst <= '0;
      r_hprot  <= '0;
    end else if (i_clear) begin
      r_pend_v <= 1'b0;
    end else if (i_capture) begin
      r_pend_v <= 1'b1;
      r_haddr  <= i_haddr;
      r_hwrite <= i_hwrite;
      r_hsize  <= i_hsize;
      r_hburst <= i_hburst;
      r_hprot  <= i_hprot;
    end
  end

  assign o_pend_v = r_pend_v;
  assign o_haddr  = r_pend_v ? r_haddr  : i_haddr;
  assign o_hwrite = r_pend_v ? r_hwrite : i_hwrite;
  assign o_hsize  = r_pend_v ? r_hsize  : i_hsize;
  assign o_hburst = r_pend_v ? r_hburst : i_hburst;
  assign o_hprot  = r_pend_v ? r_hprot  : i_hprot;

endmodule
`default_nettype wire

// File: rtl/ahb_d_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_d_arbiter
// Purpose  : Two-master AHB-Lite arbiter (core data port M0, SD DMA M1) onto
//            one data-side slave; fixed M0 priority with bounded M1 wait.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_d_arbiter
  import ahb_pkg::*;
#(
  parameter int AW       = AHB_AW,
  parameter int DW       = AHB_DW,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  // Master 0 (core data port)
  input  logic [AW-1:0] i_m0_haddr,
  input  logic [1:0]    i_m0_htrans,
  input  logic          i_m0_hwrite,
  input  logic [2:0]    i_m0_hsize,
  input  logic [2:0]    i_m0_hburst,
  input  logic [3:0]    i_m0_hprot,
  input  logic [DW-1:0] i_m0_hwdata,
  output logic          o_m0_hready,
  output logic [DW-1:0] o_m0_hrdata,
  output logic          o_m0_hresp,
  // Master 1 (SD DMA)
  input  logic [AW-1:0] i_m1_haddr,
  input  logic [1:0]    i_m1_htrans,
  input  logic          i_m1_hwrite,
  input  logic [2:0]    i_m1_hsize,
  input  logic [2:0]    i_m1_hburst,
  input  logic [3:0]    i_m1_hprot,
  input  logic [DW-1:0] i_m1_hwdata,
  output logic          o_m1_hready,
  output logic [DW-1:0] o_m1_hrdata,
  output logic          o_m1_hresp,
  // Slave
  output logic [AW-1:0] o_s_haddr,
  output logic [1:0]    o_s_htrans,
  output logic          o_s_hwrite,
  output logic [2:0]    o_s_hsize,
  output logic [2:0]    o_s_hburst,
  output logic [3:0]    o_s_hprot,
  output logic [DW-1:0] o_s_hwdata,
  input  logic          i_s_hready,
  input  logic [DW-1:0] i_s_hrdata,
  input  logic          i_s_hresp
);

  localparam int              c_cnt_w    = $clog2(MAX_WAIT + 1);
  localparam logic [c_cnt_w-1:0] c_wait_max = c_cnt_w'(MAX_WAIT);

  // Data-phase ownership and anti-starvation state
  logic               r_dp_act;
  master_e            r_dp_sel;
  logic [c_cnt_w-1:0] r_wait_cnt;

  // Address/control of the most recent grant, held on the bus while stalled
  logic [AW-1:0] r_last_haddr;
  logic          r_last_hwrite;
  logic [2:0]    r_last_hsize;
  logic [2:0]    r_last_hburst;
  logic [3:0]    r_last_hprot;

  logic          w_pend_v0,    w_pend_v1;
  logic [AW-1:0] w_src0_haddr, w_src1_haddr;
  logic          w_src0_hwrite, w_src1_hwrite;
  logic [2:0]    w_src0_hsize, w_src1_hsize;
  logic [2:0]    w_src0_hburst, w_src1_hburst;
  logic [3:0]    w_src0_hprot, w_src1_hprot;

  logic w_m0_hready, w_m1_hready;
  logic w_live0, w_live1;
  logic w_req0, w_req1;
  logic w_grant0, w_grant1, w_any_grant;
  logic w_wait_full;
  master_e w_gsel;

  logic [AW-1:0] w_g_haddr;
  logic          w_g_hwrite;
  logic [2:0]    w_g_hsize;
  logic [2:0]    w_g_hburst;
  logic [3:0]    w_g_hprot;

  // A master only stalls while its slot is full or its own data phase waits
  assign w_m0_hready = ~w_pend_v0 &
                       ((r_dp_act && r_dp_sel == GRANT_M0) ? i_s_hready : 1'b1);
  assign w_m1_hready = ~w_pend_v1 &
                       ((r_dp_act && r_dp_sel == GRANT_M1) ? i_s_hready : 1'b1);

  // Gating with rst_n keeps the slave quiet while reset is held
  assign w_live0 = rst_n & htrans_is_xfer(i_m0_htrans) & w_m0_hready;
  assign w_live1 = rst_n & htrans_is_xfer(i_m1_htrans) & w_m1_hready;
  assign w_req0  = w_pend_v0 | w_live0;
  assign w_req1  = w_pend_v1 | w_live1;

  assign w_wait_full = (r_wait_cnt == c_wait_max);
  assign w_grant1    = i_s_hready & w_req1 & (~w_req0 | w_wait_full);
  assign w_grant0    = i_s_hready & w_req0 & ~w_grant1;
  assign w_any_grant = w_grant0 | w_grant1;
  assign w_gsel      = w_grant1 ? GRANT_M1 : GRANT_M0;

  ahb_pend_slot #(.AW(AW)) u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_capture (w_live0 & ~w_grant0),
    .i_clear   (w_grant0),
    .i_haddr   (i_m0_haddr),
    .i_hwrite  (i_m0_hwrite),
    .i_hsize   (i_m0_hsize),
    .i_hburst  (i_m0_hburst),
    .i_hprot   (i_m0_hprot),
    .o_pend_v  (w_pend_v0),
    .o_haddr   (w_src0_haddr),
    .o_hwrite  (w_src0_hwrite),
    .o_hsize   (w_src0_hsize),
    .o_hburst  (w_src0_hburst),
    .o_hprot   (w_src0_hprot)
  );

  ahb_pend_slot #(.AW(AW)) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_capture (w_live1 & ~w_grant1),
    .i_clear   (w_grant1),
    .i_haddr   (i_m1_haddr),
    .i_hwrite  (i_m1_hwrite),
    .i_hsize   (i_m1_hsize),
    .i_hburst  (i_m1_hburst),
    .i_hprot   (i_m1_hprot),
    .o_pend_v  (w_pend_v1),
    .o_haddr   (w_src1_haddr),
    .o_hwrite  (w_src1_hwrite),
    .o_hsize   (w_src1_hsize),
    .o_hburst  (w_src1_hburst),
    .o_hprot   (w_src1_hprot)
  );

  assign w_g_haddr  = w_grant1 ? w_src1_haddr  : w_src0_haddr;
  assign w_g_hwrite = w_grant1 ? w_src1_hwrite : w_src0_hwrite;
  assign w_g_hsize  = w_grant1 ? w_src1_hsize  : w_src0_hsize;
  assign w_g_hburst = w_grant1 ? w_src1_hburst : w_src0_hburst;
  assign w_g_hprot  = w_grant1 ? w_src1_hprot  : w_src0_hprot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_act      <= 1'b0;
      r_dp_sel      <= GRANT_M0;
      r_wait_cnt    <= '0;
      r_last_haddr  <= '0;
      r_last_hwrite <= 1'b0;
      r_last_hsize  <= '0;
      r_last_hburst <= '0;
      r_last_hprot  <= '0;
    end else if (i_s_hready) begin
      r_dp_act <= w_any_grant;
      if (w_any_grant) begin
        r_dp_sel      <= w_gsel;
        r_last_haddr  <= w_g_haddr;
        r_last_hwrite <= w_g_hwrite;
        r_last_hsize  <= w_g_hsize;
        r_last_hburst <= w_g_hburst;
        r_last_hprot  <= w_g_hprot;
      end
      if (w_grant1 || !w_req1) begin
        r_wait_cnt <= '0;
      end else if (w_grant0 && !w_wait_full) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

  assign o_s_htrans = w_any_grant ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign o_s_haddr  = w_any_grant ? w_g_haddr  : r_last_haddr;
  assign o_s_hwrite = w_any_grant ? w_g_hwrite : r_last_hwrite;
  assign o_s_hsize  = w_any_grant ? w_g_hsize  : r_last_hsize;
  assign o_s_hburst = w_any_grant ? w_g_hburst : r_last_hburst;
  assign o_s_hprot  = w_any_grant ? w_g_hprot  : r_last_hprot;

  assign o_s_hwdata = (r_dp_sel == GRANT_M1) ? i_m1_hwdata : i_m0_hwdata;

  assign o_m0_hready = w_m0_hready;
  assign o_m1_hready = w_m1_hready;
  assign o_m0_hrdata = i_s_hrdata;
  assign o_m1_hrdata = i_s_hrdata;
  assign o_m0_hresp  = r_dp_act & (r_dp_sel == GRANT_M0) & i_s_hresp;
  assign o_m1_hresp  = r_dp_act & (r_dp_sel == GRANT_M1) & i_s_hresp;

endmodule
`default_nettype wire

// File: tb/tb_ahb_d_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_d_arbiter
// Purpose  : Self-checking bench: per-cycle vector table plus a transfer
//            scoreboard on the slave side, and a mid-transfer reset sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_d_arbiter;
  import ahb_pkg::*;

  localparam logic [1:0]  N = HTRANS_NONSEQ;
  localparam logic [1:0]  I = HTRANS_IDLE;
  localparam logic [31:0] Z = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic [1:0]  s_htrans;
  logic        s_hwrite, s_hready, s_hresp;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;

  always #5 clk = ~clk;

  ahb_d_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_m0_haddr(m0_haddr), .i_m0_htrans(m0_htrans), .i_m0_hwrite(m0_hwrite),
    .i_m0_hsize(HSIZE_WORD), .i_m0_hburst(3'b000), .i_m0_hprot(4'b0011),
    .i_m0_hwdata(m0_hwdata), .o_m0_hready(m0_hready), .o_m0_hrdata(m0_hrdata),
    .o_m0_hresp(m0_hresp),
    .i_m1_haddr(m1_haddr), .i_m1_htrans(m1_htrans), .i_m1_hwrite(m1_hwrite),
    .i_m1_hsize(HSIZE_WORD), .i_m1_hburst(3'b000), .i_m1_hprot(4'b0001),
    .i_m1_hwdata(m1_hwdata), .o_m1_hready(m1_hready), .o_m1_hrdata(m1_hrdata),
    .o_m1_hresp(m1_hresp),
    .o_s_haddr(s_haddr), .o_s_htrans(s_htrans), .o_s_hwrite(s_hwrite),
    .o_s_hsize(s_hsize), .o_s_hburst(s_hburst), .o_s_hprot(s_hprot),
    .o_s_hwdata(s_hwdata), .i_s_hready(s_hready), .i_s_hrdata(s_hrdata),
    .i_s_hresp(s_hresp)
  );

  typedef struct {
    logic [1:0] t0; logic [31:0] a0; logic w0; logic [31:0] d0;
    logic [1:0] t1; logic [31:0] a1; logic w1; logic [31:0] d1;
    logic shr; logic sresp;
    logic [1:0] e_tr; logic e_hr0, e_hr1, e_rs0, e_rs1;
    logic push; logic [31:0] pa; logic pw; logic [31:0] pd;
    logic chk_addr; logic [31:0] e_addr;
  } vec_t;

  typedef struct {
    logic [31:0] addr; logic write; logic [31:0] data;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  sb_t  cur;
  bit   dp_pend = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic vec_t mk(
      input logic [1:0] t0, input logic [31:0] a0, input int w0, input logic [31:0] d0,
      input logic [1:0] t1, input logic [31:0] a1, input int w1, input logic [31:0] d1,
      input int shr, input int sresp,
      input logic [1:0] e_tr, input int hr0, input int hr1, input int rs0, input int rs1,
      input int push, input logic [31:0] pa, input int pw, input logic [31:0] pd,
      input int ca, input logic [31:0] ea);
    vec_t v;
    v.t0 = t0; v.a0 = a0; v.w0 = (w0 != 0); v.d0 = d0;
    v.t1 = t1; v.a1 = a1; v.w1 = (w1 != 0); v.d1 = d1;
    v.shr = (shr != 0); v.sresp = (sresp != 0);
    v.e_tr = e_tr; v.e_hr0 = (hr0 != 0); v.e_hr1 = (hr1 != 0);
    v.e_rs0 = (rs0 != 0); v.e_rs1 = (rs1 != 0);
    v.push = (push != 0); v.pa = pa; v.pw = (pw != 0); v.pd = pd;
    v.chk_addr = (ca != 0); v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a falling edge: drive, sample just before the rising edge, advance
  task automatic step(input vec_t v, input int idx);
    m0_htrans = v.t0; m0_haddr = v.a0; m0_hwrite = v.w0; m0_hwdata = v.d0;
    m1_htrans = v.t1; m1_haddr = v.a1; m1_hwrite = v.w1; m1_hwdata = v.d1;
    s_hready = v.shr; s_hresp = v.sresp; s_hrdata = 32'hA500_0000 | 32'(idx);
    if (v.push) sb_q.push_back('{addr: v.pa, write: v.pw, data: v.pd});
    #4;
    chk($sformatf("r%0d_htrans", idx), 32'(s_htrans), 32'(v.e_tr));
    chk($sformatf("r%0d_m0_hready", idx), 32'(m0_hready), 32'(v.e_hr0));
    chk($sformatf("r%0d_m1_hready", idx), 32'(m1_hready), 32'(v.e_hr1));
    chk($sformatf("r%0d_m0_hresp", idx), 32'(m0_hresp), 32'(v.e_rs0));
    chk($sformatf("r%0d_m1_hresp", idx), 32'(m1_hresp), 32'(v.e_rs1));
    chk($sformatf("r%0d_m0_hrdata", idx), m0_hrdata, 32'hA500_0000 | 32'(idx));
    chk($sformatf("r%0d_m1_hrdata", idx), m1_hrdata, 32'hA500_0000 | 32'(idx));
    if (v.chk_addr) chk($sformatf("r%0d_haddr_hold", idx), s_haddr, v.e_addr);
    if (dp_pend && s_hready) begin
      if (cur.write) chk($sformatf("r%0d_sb_hwdata", idx), s_hwdata, cur.data);
      dp_pend = 1'b0;
    end
    if (s_hready && s_htrans == HTRANS_NONSEQ) begin
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL r%0d_sb_unexpected: got addr 0x%0h expected no transfer", idx, s_haddr);
      end else begin
        cur = sb_q.pop_front();
        chk($sformatf("r%0d_sb_haddr", idx), s_haddr, cur.addr);
        chk($sformatf("r%0d_sb_hwrite", idx), 32'(s_hwrite), 32'(cur.write));
        dp_pend = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    m0_htrans = I; m0_haddr = Z; m0_hwrite = 1'b0; m0_hwdata = Z;
    m1_htrans = I; m1_haddr = Z; m1_hwrite = 1'b0; m1_hwdata = Z;
    s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = Z;

    // Single write from M0, no contention
    vecs.push_back(mk(N,32'h1000,1,Z, I,Z,0,Z, 1,0, N,1,1,0,0, 1,32'h1000,1,32'hDEADBEEF, 0,Z));
    vecs.push_back(mk(I,Z,0,32'hDEADBEEF, I,Z,0,Z, 1,0, I,1,1,0,0, 0,Z,0,Z, 0,Z));
    // Simultaneous M0 read / M1 write
    vecs.push_back(mk(N,32'h2000,0,Z, N,32'h3000,1,Z, 1,0, N,1,1,0,0, 1,32'h2000,0,Z, 0,Z));
    vecs.push_back(mk(I,Z,0,Z, I,Z,0,32'h33333333, 1,0, N,1,0,0,0, 1,32'h3000,1,32'h33333333, 0,Z));
    vecs.push_back(mk(I,Z,0,Z, I,Z,0,32'h33333333, 1,0, I,1,1,0,0, 0,Z,0,Z, 0,Z));
    // Both masters saturating: M1 wins after four consecutive M0 grants
    vecs.push_back(mk(N,32'h100,0,Z, N,32'h300,0,Z, 1,0, N,1,1,0,0, 1,32'h100,0,Z, 0,Z));
    vecs.push_back(mk(N,32'h104,0,Z, N,32'h304,0,Z, 1,0, N,1,0,0,0, 1,32'h104,0,Z, 0,Z));
    vecs.push_back(mk(N,32'h108,0,Z, N,32'h304,0,Z, 1,0, N,1,0,0,0, 1,32'h108,0,Z, 0,Z));
    vecs.push_back(mk(N,32'h10C,0,Z, N,32'h304,0,Z, 1,0, N,1,0,0,0, 1,32'h10C,0,Z, 0,Z));
    vecs.push_back(mk(N,32'h110,0,Z, N,32'h304,0,Z, 1,0, N,1,0,0,0, 1,32'h300,0,Z, 0,Z));
    vecs.push_back(mk(N,32'h114,0,Z, N,32'h304,0,Z, 1,0, N,0,1,0,0, 1,32'h110,0,Z, 0,Z));
    vecs.push_back(mk(N,32'h114,0,Z, N,32'h308,0,Z, 1,0, N,1,0,0,0, 1,32'h114,0,Z, 0,Z));
    vecs.push_back(mk(N,32'h118,0,Z, N,32'h308,0,Z, 1,0, N,1,0,0,0, 1,32'h118,0,Z, 0,Z));
    vecs.push_back(mk(N,32'h11C,0,Z, N,32'h308,0,Z, 1,0, N,1,0,0,0, 1,32'h11C,0,Z, 0,Z));
    vecs.push_back(mk(N,32'h120,0,Z, N,32'h308,0,Z, 1,0, N,1,0,0,0, 1,32'h304,0,Z, 0,Z));
    vecs.push_back(mk(I,Z,0,Z, N,32'h308,0,Z, 1,0, N,0,1,0,0, 1,32'h120,0,Z, 0,Z));
    vecs.push_back(mk(I,Z,0,Z, I,Z,0,Z, 1,0, N,1,0,0,0, 1,32'h308,0,Z, 0,Z));
    vecs.push_back(mk(I,Z,0,Z, I,Z,0,Z, 1,0, I,1,1,0,0, 0,Z,0,Z, 0,Z));
    // Slave wait states on an M0 read; M1 arrives during the stall
    vecs.push_back(mk(N,32'h4000,0,Z, I,Z,0,Z, 1,0, N,1,1,0,0, 1,32'h4000,0,Z, 0,Z));
    vecs.push_back(mk(I,Z,0,Z, N,32'h5000,1,Z, 0,0, I,0,1,0,0, 0,Z,0,Z, 1,32'h4000));
    vecs.push_back(mk(I,Z,0,Z, I,Z,0,32'h55555555, 0,0, I,0,0,0,0, 0,Z,0,Z, 1,32'h4000));
    vecs.push_back(mk(I,Z,0,Z, I,Z,0,32'h55555555, 1,0, N,1,0,0,0, 1,32'h5000,1,32'h55555555, 0,Z));
    vecs.push_back(mk(I,Z,0,Z, I,Z,0,32'h55555555, 1,0, I,1,1,0,0, 0,Z,0,Z, 0,Z));
    // Two-cycle error response on an M1 write
    vecs.push_back(mk(I,Z,0,Z, N,32'h6000,1,Z, 1,0, N,1,1,0,0, 1,32'h6000,1,32'h66666666, 0,Z));
    vecs.push_back(mk(I,Z,0,Z, I,Z,0,32'h66666666, 0,1, I,1,0,0,1, 0,Z,0,Z, 0,Z));
    vecs.push_back(mk(I,Z,0,Z, I,Z,0,32'h66666666, 1,1, I,1,1,0,1, 0,Z,0,Z, 0,Z));
    vecs.push_back(mk(I,Z,0,Z, I,Z,0,Z, 1,0, I,1,1,0,0, 0,Z,0,Z, 0,Z));

    // Reset state
    @(negedge clk);
    m0_htrans = N; m0_haddr = 32'h0BAD;
    #4;
    chk("rst_htrans", 32'(s_htrans), 32'(HTRANS_IDLE));
    chk("rst_m0_hready", 32'(m0_hready), 32'd1);
    chk("rst_m1_hready", 32'(m1_hready), 32'd1);
    chk("rst_m0_hresp", 32'(m0_hresp), 32'd0);
    chk("rst_m1_hresp", 32'(m1_hresp), 32'd0);
    @(negedge clk);
    m0_htrans = I;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Reset while M1 is pending and the slave is stalling an M0 read
    step(mk(N,32'h7000,0,Z, N,32'h8000,1,Z, 1,0, N,1,1,0,0, 1,32'h7000,0,Z, 0,Z), 100);
    step(mk(I,Z,0,Z, I,Z,0,32'h88888888, 0,0, I,0,0,0,0, 0,Z,0,Z, 0,Z), 101);
    s_hresp = 1'b1; m0_htrans = N; m0_haddr = 32'h7004;
    #1;
    chk("pre_rst_m1_hready", 32'(m1_hready), 32'd0);
    chk("pre_rst_m0_hresp", 32'(m0_hresp), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_htrans", 32'(s_htrans), 32'(HTRANS_IDLE));
    chk("mid_rst_m0_hready", 32'(m0_hready), 32'd1);
    chk("mid_rst_m1_hready", 32'(m1_hready), 32'd1);
    chk("mid_rst_m0_hresp", 32'(m0_hresp), 32'd0);
    chk("mid_rst_m1_hresp", 32'(m1_hresp), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dp_pend = 1'b0;
    step(mk(I,Z,0,Z, I,Z,0,Z, 1,0, I,1,1,0,0, 0,Z,0,Z, 0,Z), 102);
    step(mk(I,Z,0,Z, N,32'h9000,1,Z, 1,0, N,1,1,0,0, 1,32'h9000,1,32'h99999999, 0,Z), 103);
    step(mk(I,Z,0,Z, I,Z,0,32'h99999999, 1,0, I,1,1,0,0, 0,Z,0,Z, 0,Z), 104);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
